fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Owns the architectural fetch PC, directly downstream of the PC select mux.
//   Sends sequential PC+4 back to the mux and takes the selected next PC from it.
//   Issues in-order instruction-memory requests over a valid/ready handshake.
//   Buffers responses and hands {pc, inst} to decode; on redirect it kills the queue and drops stale responses.
// PARAMETERS
//   RESET_PC  32'h0000_0200  PC value loaded on reset.
//   QDEPTH    2              Max requests in flight plus buffered entries (power of 2, >=2).
// PORTS
//   clk                 in   1   Single clock; all state updates on posedge.
//   reset               in   1   Asynchronous, active-high reset.
//   io_pc_redirect      in   1   Non-sequential next PC valid this cycle (mux select != pc4).
//   io_pc_next          in   32  Next PC from the PC select mux.
//   io_pc_pc4           out  32  Current fetch PC + 4, fed to the mux pc4 input.
//   io_imem_req_valid   out  1   Fetch request valid.
//   io_imem_req_ready   in   1   Memory accepts the request.
//   io_imem_req_addr    out  32  Fetch address (= current PC).
//   io_imem_resp_valid  in   1   Response valid; in order, latency >= 1 cycle, no backpressure.
//   io_imem_resp_data   in   32  Instruction word.
//   io_dec_valid        out  1   Decode entry valid.
//   io_dec_ready        in   1   Decode accepts the entry.
//   io_dec_pc           out  32  PC of the presented instruction.
//   io_dec_inst         out  32  Presented instruction.
//   io_dec_misalign     out  1   Misaligned-target marker; tied 0 unless the macro is enabled.
// BEHAVIOUR
//   Reset: pc=RESET_PC; all FIFOs empty; outstanding=0; drop_cnt=0.
//     All outputs are low or zero, except io_pc_pc4=RESET_PC+4 and io_imem_req_addr=RESET_PC.
//   A reset mid-operation discards all state; imem shares this reset, so no pre-reset response arrives.
//   Credit: occ = outstanding + outq_count. req_valid = !io_pc_redirect && (occ < QDEPTH) && drop_cnt==0.
//   Request fire (valid&&ready): tag FIFO pushes pc, outstanding++, pc <= pc+4.
//     No fire: pc holds. pc+4 wraps modulo 2^32.
//   Response with drop_cnt==0: pop tag FIFO, push {tag,data} to the output queue, outstanding--.
//     Push and pop of the output queue in the same cycle are legal.
//   Response with drop_cnt>0: discard the word, drop_cnt--, outstanding--.
//   Output: io_dec_valid = outq non-empty; head pops on valid&&ready.
//     A response arriving into an empty queue is visible the following cycle.
//     The output is registered, so no combinational resp->dec path.
//   Redirect (priority over all, one cycle):
//     - pc <= io_pc_next; no request issued this cycle.
//     - Output queue and tag FIFO are flushed.
//     - drop_cnt <= outstanding minus 1 if a response arrives this cycle; that response is discarded.
//     - A decode pop in the same cycle is void, since the flushed entry is lost.
//   Back-to-back redirects: the last one wins; drop_cnt accumulates correctly because it is recomputed from outstanding.
//   Full queue with dec_ready=0: requests stop, pc holds, and no response is lost (guaranteed by credit).
// CONFIGURATION
//   FETCH_MISALIGN_EN defined:
//     - A redirect to io_pc_next[1:0]!=0 latches pc=target and suppresses imem requests.
//     - After drain, one entry {pc=target, inst=32'h0000_0013, misalign=1} is presented.
//     - After it is accepted the stage idles until the next redirect.
//   FETCH_MISALIGN_EN undefined:
//     - io_pc_next[1:0] are forced to 2'b00 on redirect; io_dec_misalign is constant 0.
// TESTING
//   T1 reset release, req_ready=1, 1-cycle imem, dec_ready=1:
//      addrs 0x200, 0x204, 0x208...; dec_pc follows 2 cycles after the matching request; pc4=0x204 at reset.
//   T2 dec_ready=0 for 10 cycles:
//      exactly QDEPTH requests issued, pc holds; on release, in-order dec of 0x200 and 0x204 with no loss.
//   T3 two requests outstanding (latency 3), redirect to 0x1000:
//      both responses dropped, next req_addr=0x1000, first dec_pc=0x1000.
//   T4 redirect in the same cycle as a response and dec_ready=1:
//      response discarded, no dec fire is counted, drop_cnt = outstanding-1.
//   T5 reset asserted mid-stream with a full queue:
//      dec_valid and req_valid drop immediately; after release, addr=0x200.
//   T6 (FETCH_MISALIGN_EN) redirect to 0x1002:
//      no imem request, dec entry pc=0x1002 misalign=1 inst=0x13.
//      Without the macro, addr=0x1000 and misalign=0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Owns the architectural fetch PC. It sends PC+4 back to the PC select mux and
//   takes the selected next PC from it. It issues in-order instruction-memory
//   requests over a valid/ready handshake, buffers the responses together with
//   their PCs, and presents {pc, inst} to decode. A redirect flushes all
//   buffered work and arranges for responses that are still in flight to be
//   dropped as they arrive.
//
//   Optional feature macro: FETCH_MISALIGN_EN
//     defined   : a redirect to a non word-aligned target latches that target,
//                 suppresses memory requests, and, once in-flight responses
//                 have drained, presents one entry {pc=target, inst=NOP,
//                 misalign=1}. The stage then idles until the next redirect.
//     undefined : bits [1:0] of the redirect target are forced to zero and
//                 io_dec_misalign is constant 0.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   io_pc_redirect      a non-sequential next PC is selected this cycle
//   io_pc_next          next PC from the PC select mux
//   io_pc_pc4           current fetch PC + 4, returned to the mux
//   io_imem_req_*       fetch request (valid/ready, addr = current PC)
//   io_imem_resp_*      in-order response, latency >= 1, no backpressure
//   io_dec_*            decode entry (valid/ready, pc, inst, misalign marker)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_pc_redirect,
  input  logic [31:0] io_pc_next,
  output logic [31:0] io_pc_pc4,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_dec_valid,
  input  logic        io_dec_ready,
  output logic [31:0] io_dec_pc,
  output logic [31:0] io_dec_inst,
  output logic        io_dec_misalign
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [OW-1:0] QDEPTH_OCC = OW'(QDEPTH);

  logic [31:0]   pc;

  // Tag FIFO: PCs of requests whose responses are still expected.
  logic [31:0]   tag_mem [QDEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  // Output queue towards decode.
  logic [31:0]   oq_pc   [QDEPTH];
  logic [31:0]   oq_inst [QDEPTH];
  logic [AW-1:0] oq_wr;
  logic [AW-1:0] oq_rd;
  logic [CW-1:0] oq_cnt;

  // outstanding counts every request not yet answered, including those whose
  // answers will be dropped; drop_cnt counts the ones that will be dropped.
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [OW-1:0] occ;

  logic          req_block;
  logic          mis_push;
  logic          req_fire;
  logic          resp_keep;
  logic          oq_push;
  logic          oq_pop;
  logic [31:0]   redirect_pc;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {ST_RUN, ST_MIS_WAIT, ST_MIS_IDLE} state_t;
  state_t state;
  logic   oq_mis [QDEPTH];

  assign redirect_pc = io_pc_next;
  assign req_block   = (state != ST_RUN);
  // After a misaligned redirect no new requests are made, so once the dropped
  // responses have drained the queue is empty and the marker entry can go in.
  assign mis_push    = (state == ST_MIS_WAIT) && !io_pc_redirect &&
                       (outstanding == '0) && (drop_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else if (io_pc_redirect) begin
      state <= (io_pc_next[1:0] != 2'b00) ? ST_MIS_WAIT : ST_RUN;
    end else if (mis_push) begin
      state <= ST_MIS_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (oq_push) oq_mis[oq_wr] <= mis_push;
  end

  assign io_dec_misalign = io_dec_valid && oq_mis[oq_rd];
`else
  assign redirect_pc     = io_pc_next & 32'hFFFF_FFFC;
  assign req_block       = 1'b0;
  assign mis_push        = 1'b0;
  assign io_dec_misalign = 1'b0;
`endif

  // Credit covers both in-flight requests and buffered entries, so a response
  // always finds room in the output queue even while decode stalls.
  assign occ               = OW'(outstanding) + OW'(oq_cnt);
  assign io_imem_req_valid = !reset && !io_pc_redirect && !req_block &&
                             (occ < QDEPTH_OCC) && (drop_cnt == '0);
  assign io_imem_req_addr  = pc;
  assign io_pc_pc4         = pc + 32'd4;

  assign req_fire  = io_imem_req_valid && io_imem_req_ready;
  assign resp_keep = io_imem_resp_valid && (drop_cnt == '0) && !io_pc_redirect;
  assign oq_push   = resp_keep || mis_push;
  assign oq_pop    = io_dec_valid && io_dec_ready && !io_pc_redirect;
  assign push_pc   = mis_push ? pc : tag_mem[tag_rd];
  assign push_inst = mis_push ? 32'h0000_0013 : io_imem_resp_data;

  assign io_dec_valid = (oq_cnt != '0);
  assign io_dec_pc    = io_dec_valid ? oq_pc[oq_rd]   : 32'h0;
  assign io_dec_inst  = io_dec_valid ? oq_inst[oq_rd] : 32'h0;

  // Control state: PC, pointers and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      tag_wr      <= '0;
      tag_rd      <= '0;
      oq_wr       <= '0;
      oq_rd       <= '0;
      oq_cnt      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (io_pc_redirect) begin
      // Everything still in flight becomes stale; a response arriving right
      // now is discarded here, so it is not counted again.
      pc          <= redirect_pc;
      tag_wr      <= '0;
      tag_rd      <= '0;
      oq_wr       <= '0;
      oq_rd       <= '0;
      oq_cnt      <= '0;
      outstanding <= outstanding - CW'(io_imem_resp_valid);
      drop_cnt    <= outstanding - CW'(io_imem_resp_valid);
    end else begin
      if (req_fire) begin
        pc     <= pc + 32'd4;
        tag_wr <= tag_wr + 1'b1;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(io_imem_resp_valid);
      if (io_imem_resp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else                tag_rd   <= tag_rd + 1'b1;
      end
      if (oq_push) oq_wr <= oq_wr + 1'b1;
      if (oq_pop)  oq_rd <= oq_rd + 1'b1;
      oq_cnt <= oq_cnt + CW'(oq_push) - CW'(oq_pop);
    end
  end

  // Storage: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= pc;
    if (oq_push) begin
      oq_pc[oq_wr]   <= push_pc;
      oq_inst[oq_wr] <= push_inst;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. An instruction-memory model answers
//   requests in order after a random latency with data derived from the
//   address. Every request and decode handshake is logged together with an
//   epoch number that advances on each redirect or reset; expected behaviour
//   is expressed over these logs: requests of an epoch walk up from the epoch
//   target by 4, and decode entries of an epoch are that epoch's requests in
//   order with matching instruction words.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0200;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_pc_redirect;
  logic [31:0] io_pc_next;
  logic [31:0] io_pc_pc4;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_dec_valid;
  logic        io_dec_ready;
  logic [31:0] io_dec_pc;
  logic [31:0] io_dec_inst;
  logic        io_dec_misalign;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .io_pc_redirect     (io_pc_redirect),
    .io_pc_next         (io_pc_next),
    .io_pc_pc4          (io_pc_pc4),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_dec_valid       (io_dec_valid),
    .io_dec_ready       (io_dec_ready),
    .io_dec_pc          (io_dec_pc),
    .io_dec_inst        (io_dec_inst),
    .io_dec_misalign    (io_dec_misalign)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int epoch   = 0;
  logic [31:0] ep_target [int];

  // Handshake logs.
  logic [31:0] rq_addr [$];
  int          rq_ep   [$];
  int          rq_cyc  [$];
  logic [31:0] dq_pc   [$];
  logic [31:0] dq_inst [$];
  logic        dq_mis  [$];
  int          dq_ep   [$];
  int          dq_cyc  [$];

  // Instruction-memory model.
  logic [31:0] im_addr [$];
  int          im_due  [$];
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int first_req(input int ep);
    foreach (rq_ep[i]) if (rq_ep[i] == ep) return i;
    return -1;
  endfunction

  function automatic int first_dec(input int ep);
    foreach (dq_ep[i]) if (dq_ep[i] == ep) return i;
    return -1;
  endfunction

  function automatic int count_req(input int ep);
    int n = 0;
    foreach (rq_ep[i]) if (rq_ep[i] == ep) n++;
    return n;
  endfunction

  function automatic int count_dec(input int ep);
    int n = 0;
    foreach (dq_ep[i]) if (dq_ep[i] == ep) n++;
    return n;
  endfunction

  task automatic clear_logs();
    rq_addr.delete(); rq_ep.delete(); rq_cyc.delete();
    dq_pc.delete(); dq_inst.delete(); dq_mis.delete(); dq_ep.delete(); dq_cyc.delete();
  endtask

  // One clock cycle: entered just after a falling edge with the caller's
  // inputs applied; drives the memory response, samples, logs handshakes.
  task automatic step();
    int due;
    if (im_addr.size() > 0 && im_due[0] <= cyc) begin
      io_imem_resp_valid = 1'b1;
      io_imem_resp_data  = hash(im_addr.pop_front());
      void'(im_due.pop_front());
    end else begin
      io_imem_resp_valid = 1'b0;
      io_imem_resp_data  = $urandom;
    end
    #1;
    if (io_imem_req_valid && io_imem_req_ready) begin
      rq_addr.push_back(io_imem_req_addr);
      rq_ep.push_back(epoch);
      rq_cyc.push_back(cyc);
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      im_addr.push_back(io_imem_req_addr);
      im_due.push_back(due);
    end
    if (io_dec_valid && io_dec_ready && !io_pc_redirect) begin
      dq_pc.push_back(io_dec_pc);
      dq_inst.push_back(io_dec_inst);
      dq_mis.push_back(io_dec_misalign);
      dq_ep.push_back(epoch);
      dq_cyc.push_back(cyc);
    end
    if (io_pc_redirect) begin
      epoch++;
`ifdef FETCH_MISALIGN_EN
      ep_target[epoch] = io_pc_next;
`else
      ep_target[epoch] = io_pc_next & 32'hFFFF_FFFC;
`endif
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    io_pc_redirect     = 1'b0;
    io_imem_resp_valid = 1'b0;
    im_addr.delete();
    im_due.delete();
    last_due = cyc;
    epoch++;
    ep_target[epoch] = RESET_PC;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_pc_redirect = 1'b0; io_pc_next = 32'h0; io_imem_resp_valid = 1'b0;
    io_imem_resp_data = 32'h0; io_imem_req_ready = 1'b1; io_dec_ready = 1'b1;
    epoch++;
    ep_target[epoch] = RESET_PC;
    @(posedge clk); cyc++;
    @(negedge clk);
    #1;
    n_tests++; if (io_imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", io_imem_req_valid); end
    n_tests++; if (io_dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid: got %b want 0", io_dec_valid); end
    n_tests++; if (io_pc_pc4 !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL rst_pc4: got %h want %h", io_pc_pc4, RESET_PC + 32'd4); end
    n_tests++; if (io_imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_addr: got %h want %h", io_imem_req_addr, RESET_PC); end
    n_tests++; if (io_dec_pc !== 32'h0 || io_dec_inst !== 32'h0 || io_dec_misalign !== 1'b0) begin
      n_fail++; $display("FAIL rst_dec_data: got pc %h inst %h mis %b want zeros", io_dec_pc, io_dec_inst, io_dec_misalign);
    end
    reset = 1'b0;
    #1;
    n_tests++; if (io_imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_release_req: got %b want 1", io_imem_req_valid); end
    clear_logs();
  endtask

  // T1: streaming with single-cycle memory.
  task automatic test_sequential();
    do_reset();
    lat_min = 1; lat_max = 1; io_imem_req_ready = 1'b1; io_dec_ready = 1'b1;
    repeat (24) step();
    n_tests++; if (rq_addr.size() < 8) begin n_fail++; $display("FAIL t1_req_count: got %0d want >=8", rq_addr.size()); end
    foreach (rq_addr[i]) begin
      n_tests++;
      if (rq_addr[i] !== RESET_PC + 32'(4 * i)) begin n_fail++; $display("FAIL t1_addr[%0d]: got %h want %h", i, rq_addr[i], RESET_PC + 32'(4 * i)); end
    end
    n_tests++; if (dq_pc.size() < 6) begin n_fail++; $display("FAIL t1_dec_count: got %0d want >=6", dq_pc.size()); end
    foreach (dq_pc[i]) begin
      n_tests++;
      if (dq_pc[i] !== RESET_PC + 32'(4 * i) || dq_inst[i] !== hash(RESET_PC + 32'(4 * i))) begin
        n_fail++; $display("FAIL t1_dec[%0d]: got pc %h inst %h want pc %h inst %h", i, dq_pc[i], dq_inst[i], RESET_PC + 32'(4 * i), hash(RESET_PC + 32'(4 * i)));
      end
      n_tests++;
      if (i >= rq_cyc.size() || dq_cyc[i] !== rq_cyc[i] + 2) begin
        n_fail++; $display("FAIL t1_latency[%0d]: dec cycle %0d, request cycle %0d, want +2", i, dq_cyc[i], (i < rq_cyc.size()) ? rq_cyc[i] : -1);
      end
    end
  endtask

  // T2: decode stalled, credit limit, then release.
  task automatic test_backpressure();
    do_reset();
    lat_min = 1; lat_max = 1; io_imem_req_ready = 1'b1; io_dec_ready = 1'b0;
    repeat (10) step();
    #1;
    n_tests++; if (rq_addr.size() != QDEPTH) begin n_fail++; $display("FAIL t2_req_count: got %0d want %0d", rq_addr.size(), QDEPTH); end
    n_tests++; if (io_imem_req_addr !== RESET_PC + 32'(4 * QDEPTH)) begin n_fail++; $display("FAIL t2_pc_hold: got %h want %h", io_imem_req_addr, RESET_PC + 32'(4 * QDEPTH)); end
    n_tests++; if (io_imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL t2_req_stop: got %b want 0", io_imem_req_valid); end
    n_tests++; if (io_dec_valid !== 1'b1) begin n_fail++; $display("FAIL t2_dec_valid: got %b want 1", io_dec_valid); end
    io_dec_ready = 1'b1;
    repeat (10) step();
    n_tests++; if (dq_pc.size() < 3) begin n_fail++; $display("FAIL t2_dec_count: got %0d want >=3", dq_pc.size()); end
    foreach (dq_pc[i]) begin
      n_tests++;
      if (dq_pc[i] !== RESET_PC + 32'(4 * i) || dq_inst[i] !== hash(RESET_PC + 32'(4 * i))) begin
        n_fail++; $display("FAIL t2_dec[%0d]: got pc %h inst %h want pc %h", i, dq_pc[i], dq_inst[i], RESET_PC + 32'(4 * i));
      end
    end
  endtask

  // T3: redirect with two requests in flight at latency 3.
  task automatic test_redirect_drop();
    int old_ep;
    int idx;
    do_reset();
    lat_min = 3; lat_max = 3; io_imem_req_ready = 1'b1; io_dec_ready = 1'b1;
    step(); step();
    old_ep = epoch;
    io_pc_redirect = 1'b1; io_pc_next = 32'h0000_1000;
    step();
    io_pc_redirect = 1'b0;
    repeat (14) begin io_pc_next = $urandom; step(); end
    n_tests++; if (count_req(old_ep) != 2) begin n_fail++; $display("FAIL t3_old_reqs: got %0d want 2", count_req(old_ep)); end
    n_tests++; if (count_dec(old_ep) != 0) begin n_fail++; $display("FAIL t3_old_decs: got %0d want 0", count_dec(old_ep)); end
    idx = first_req(old_ep + 1);
    n_tests++; if (idx < 0 || rq_addr[idx] !== 32'h0000_1000) begin n_fail++; $display("FAIL t3_first_req: idx %0d addr %h want 00001000", idx, (idx >= 0) ? rq_addr[idx] : 32'h0); end
    idx = first_dec(old_ep + 1);
    n_tests++; if (idx < 0 || dq_pc[idx] !== 32'h0000_1000 || dq_inst[idx] !== hash(32'h0000_1000)) begin
      n_fail++; $display("FAIL t3_first_dec: idx %0d pc %h want 00001000", idx, (idx >= 0) ? dq_pc[idx] : 32'h0);
    end
  endtask

  // T4: redirect in the cycle a response arrives while decode is taking an entry.
  task automatic test_redirect_with_resp();
    bit found = 0;
    int idx;
    int ep_new;
    do_reset();
    lat_min = 1; lat_max = 1; io_imem_req_ready = 1'b1; io_dec_ready = 1'b1;
    for (int n = 0; n < 50 && !found; n++) begin
      if (io_dec_valid && im_addr.size() > 0 && im_due[0] <= cyc) found = 1;
      else step();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL t4_setup: no cycle with response and decode entry within 50 cycles"); end
    io_pc_redirect = 1'b1; io_pc_next = 32'h0000_2000;
    step();
    ep_new = epoch;
    io_pc_redirect = 1'b0;
    #1;
    n_tests++; if (io_dec_valid !== 1'b0) begin n_fail++; $display("FAIL t4_dec_flushed: got %b want 0", io_dec_valid); end
    n_tests++; if (io_imem_req_valid !== 1'b1 || io_imem_req_addr !== 32'h0000_2000) begin
      n_fail++; $display("FAIL t4_req_resume: got valid %b addr %h want 1 00002000", io_imem_req_valid, io_imem_req_addr);
    end
    repeat (8) step();
    idx = first_dec(ep_new);
    n_tests++; if (idx < 0 || dq_pc[idx] !== 32'h0000_2000) begin n_fail++; $display("FAIL t4_first_dec: idx %0d pc %h want 00002000", idx, (idx >= 0) ? dq_pc[idx] : 32'h0); end
  endtask

  // T5: reset asserted with a full queue.
  task automatic test_reset_mid();
    int idx;
    do_reset();
    lat_min = 1; lat_max = 2; io_imem_req_ready = 1'b1; io_dec_ready = 1'b0;
    repeat (8) step();
    n_tests++; if (io_dec_valid !== 1'b1) begin n_fail++; $display("FAIL t5_full: dec_valid got %b want 1", io_dec_valid); end
    reset = 1'b1;
    io_imem_resp_valid = 1'b0;
    #1;
    n_tests++; if (io_dec_valid !== 1'b0 || io_imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL t5_async: dec_valid %b req_valid %b want 0 0", io_dec_valid, io_imem_req_valid);
    end
    im_addr.delete(); im_due.delete(); last_due = cyc;
    epoch++;
    ep_target[epoch] = RESET_PC;
    @(posedge clk); cyc++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++; if (io_imem_req_addr !== RESET_PC || io_imem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL t5_restart: addr %h valid %b want %h 1", io_imem_req_addr, io_imem_req_valid, RESET_PC);
    end
    io_dec_ready = 1'b1;
    repeat (10) step();
    idx = first_dec(epoch);
    n_tests++; if (idx < 0 || dq_pc[idx] !== RESET_PC) begin n_fail++; $display("FAIL t5_first_dec: idx %0d pc %h want %h", idx, (idx >= 0) ? dq_pc[idx] : 32'h0, RESET_PC); end
  endtask

  // T6: redirect to a misaligned target.
  task automatic test_misalign();
    int ep_new;
    int idx;
    do_reset();
    lat_min = 1; lat_max = 2; io_imem_req_ready = 1'b1; io_dec_ready = 1'b1;
    repeat (4) step();
    io_pc_redirect = 1'b1; io_pc_next = 32'h0000_1002;
    step();
    ep_new = epoch;
    io_pc_redirect = 1'b0;
    repeat (12) step();
`ifdef FETCH_MISALIGN_EN
    n_tests++; if (count_req(ep_new) != 0) begin n_fail++; $display("FAIL t6_no_req: got %0d requests want 0", count_req(ep_new)); end
    idx = first_dec(ep_new);
    n_tests++; if (count_dec(ep_new) != 1 || idx < 0) begin n_fail++; $display("FAIL t6_dec_count: got %0d want 1", count_dec(ep_new)); end
    else if (dq_pc[idx] !== 32'h0000_1002 || dq_inst[idx] !== 32'h0000_0013 || dq_mis[idx] !== 1'b1) begin
      n_fail++; $display("FAIL t6_entry: pc %h inst %h mis %b want 00001002 00000013 1", dq_pc[idx], dq_inst[idx], dq_mis[idx]);
    end
    #1;
    n_tests++; if (io_dec_valid !== 1'b0 || io_imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL t6_idle: dec_valid %b req_valid %b want 0 0", io_dec_valid, io_imem_req_valid);
    end
    io_pc_redirect = 1'b1; io_pc_next = 32'h0000_3000;
    step();
    io_pc_redirect = 1'b0;
    repeat (6) step();
    idx = first_req(epoch);
    n_tests++; if (idx < 0 || rq_addr[idx] !== 32'h0000_3000) begin n_fail++; $display("FAIL t6_resume: idx %0d addr %h want 00003000", idx, (idx >= 0) ? rq_addr[idx] : 32'h0); end
`else
    idx = first_req(ep_new);
    n_tests++; if (idx < 0 || rq_addr[idx] !== 32'h0000_1000) begin n_fail++; $display("FAIL t6_aligned_req: idx %0d addr %h want 00001000", idx, (idx >= 0) ? rq_addr[idx] : 32'h0); end
    idx = first_dec(ep_new);
    n_tests++; if (idx < 0 || dq_pc[idx] !== 32'h0000_1000 || dq_mis[idx] !== 1'b0) begin
      n_fail++; $display("FAIL t6_aligned_dec: idx %0d pc %h mis %b want 00001000 0", idx, (idx >= 0) ? dq_pc[idx] : 32'h0, (idx >= 0) ? dq_mis[idx] : 1'b0);
    end
`endif
  endtask

  // PC increment wraps modulo 2^32.
  task automatic test_wrap();
    int idx;
    logic [31:0] want;
    do_reset();
    lat_min = 1; lat_max = 1; io_imem_req_ready = 1'b1; io_dec_ready = 1'b1;
    io_pc_redirect = 1'b1; io_pc_next = 32'hFFFF_FFF8;
    step();
    io_pc_redirect = 1'b0;
    repeat (14) step();
    idx = first_req(epoch);
    for (int k = 0; k < 4; k++) begin
      want = 32'hFFFF_FFF8 + 32'(4 * k);
      n_tests++;
      if (idx < 0 || idx + k >= rq_addr.size() || rq_addr[idx + k] !== want) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, (idx >= 0 && idx + k < rq_addr.size()) ? rq_addr[idx + k] : 32'h0, want);
      end
    end
  endtask

  // Random traffic with random redirects, then drain.
  task automatic test_random();
    int cur_ep;
    int k;
    int p;
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int n = 0; n < 2000; n++) begin
      io_imem_req_ready = ($urandom_range(3, 0) != 0);
      io_dec_ready      = ($urandom_range(3, 0) != 0);
      io_pc_redirect    = ($urandom_range(29, 0) == 0);
      io_pc_next        = io_pc_redirect ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      step();
    end
    io_pc_redirect = 1'b0; io_imem_req_ready = 1'b0; io_dec_ready = 1'b1;
    repeat (30) step();

    cur_ep = -1; k = 0;
    foreach (rq_addr[i]) begin
      if (rq_ep[i] != cur_ep) begin cur_ep = rq_ep[i]; k = 0; end
      n_tests++;
      if (rq_addr[i] !== ep_target[cur_ep] + 32'(4 * k)) begin
        n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h (epoch %0d)", i, rq_addr[i], ep_target[cur_ep] + 32'(4 * k), cur_ep);
      end
      k++;
    end
    p = 0;
    foreach (dq_pc[j]) begin
      while (p < rq_addr.size() && rq_ep[p] < dq_ep[j]) p++;
      n_tests++;
      if (p >= rq_addr.size() || rq_ep[p] != dq_ep[j] || dq_pc[j] !== rq_addr[p] ||
          dq_inst[j] !== hash(rq_addr[p]) || dq_mis[j] !== 1'b0) begin
        n_fail++; $display("FAIL rnd_dec[%0d]: got pc %h inst %h mis %b want pc %h inst %h", j, dq_pc[j], dq_inst[j], dq_mis[j],
                           (p < rq_addr.size()) ? rq_addr[p] : 32'h0, (p < rq_addr.size()) ? hash(rq_addr[p]) : 32'h0);
      end
      p++;
    end
    n_tests++; if (count_dec(epoch) != count_req(epoch)) begin
      n_fail++; $display("FAIL rnd_drain: decoded %0d of %0d requests", count_dec(epoch), count_req(epoch));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_with_resp();
    test_reset_mid();
    test_misalign();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
